// File: rtl/tl_ram_pkg.sv
// Shared TileLink-UL opcodes, field widths and the D-channel response record
// used by the single-beat RAM slave and its response queue.
package tl_ram_pkg;

  localparam int SRC_W  = 11;
  localparam int ADDR_W = 29;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int SIZE_W = 2;

  localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL    = 3'd1;
  localparam logic [2:0] TL_A_GET           = 3'd4;
  localparam logic [2:0] TL_A_INTENT        = 3'd5;
  localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;
  localparam logic [2:0] TL_D_HINTACK       = 3'd2;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [DATA_W-1:0] data;
  } tl_d_resp_t;

  // Pointer advance for a 3-slot ring.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/tl_ram_resp_queue.sv
// Three-entry in-order FIFO of D responses; head is presented combinationally.
module tl_ram_resp_queue
  import tl_ram_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  tl_d_resp_t push_data,
  input  logic       pop,
  output tl_d_resp_t head,
  output logic [1:0] count
);

  tl_d_resp_t slots [3];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  assign head = slots[rd_ptr];

  // Admission upstream guarantees neither of these can happen.
  assert property (@(posedge clock) disable iff (reset) !(pop && count == 2'd0));
  assert property (@(posedge clock) disable iff (reset) !(push && count == 2'd3));

endmodule

// File: rtl/tl_ram_slave.sv
// Single-beat TileLink-UL RAM slave: one request per cycle into s1, then a
// 3-entry response queue onto D; A ready depends only on registered occupancy.
module tl_ram_slave
  import tl_ram_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              auto_in_a_valid,
  output logic              auto_in_a_ready,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [SIZE_W-1:0] auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0] auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  output logic              auto_in_d_valid,
  input  logic              auto_in_d_ready,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [SIZE_W-1:0] auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic [DATA_W-1:0] auto_in_d_bits_data
);

  logic [DATA_W-1:0] ram [DEPTH_WORDS];

  logic [IDX_W-1:0] a_idx;
  logic             a_fire;
  logic             a_is_put;
  logic [DATA_W-1:0] rd_word;
  tl_d_resp_t       s1_next;
  tl_d_resp_t       s1_resp;
  logic             s1_valid;
  tl_d_resp_t       q_head;
  tl_d_resp_t       d_resp;
  logic [1:0]       q_count;
  logic [2:0]       occupancy;
  logic             d_fire;
  logic             unused_a_bits;

  // Param and the non-index address bits carry no meaning for this slave.
  assign unused_a_bits = ^{auto_in_a_bits_param, auto_in_a_bits_address};

  assign a_idx     = auto_in_a_bits_address[3 +: IDX_W];
  assign occupancy = {1'b0, q_count} + {2'b00, s1_valid};
  assign auto_in_a_ready = !reset && (occupancy < 3'd3);
  assign a_fire    = auto_in_a_valid && auto_in_a_ready;
  assign a_is_put  = (auto_in_a_bits_opcode == TL_A_PUTFULL) ||
                     (auto_in_a_bits_opcode == TL_A_PUTPARTIAL);
  assign rd_word   = ram[a_idx];

  always_ff @(posedge clock) begin
    if (a_fire && a_is_put && !auto_in_a_bits_corrupt) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (auto_in_a_bits_mask[i]) ram[a_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    s1_next        = '0;
    s1_next.size   = auto_in_a_bits_size;
    s1_next.source = auto_in_a_bits_source;
    case (auto_in_a_bits_opcode)
      TL_A_PUTFULL, TL_A_PUTPARTIAL: s1_next.opcode = TL_D_ACCESSACK;
      TL_A_INTENT:                   s1_next.opcode = TL_D_HINTACK;
      // Get and the unsupported opcodes both return the current word.
      default: begin
        s1_next.opcode = TL_D_ACCESSACKDATA;
        s1_next.data   = rd_word;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= a_fire;
  end

  always_ff @(posedge clock) begin
    if (a_fire) s1_resp <= s1_next;
  end

  tl_ram_resp_queue u_resp_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (s1_valid),
    .push_data (s1_resp),
    .pop       (d_fire),
    .head      (q_head),
    .count     (q_count)
  );

  assign auto_in_d_valid = !reset && (q_count != 2'd0);
  assign d_fire          = auto_in_d_valid && auto_in_d_ready;
  assign d_resp          = auto_in_d_valid ? q_head : '0;

  assign auto_in_d_bits_opcode = d_resp.opcode;
  assign auto_in_d_bits_size   = d_resp.size;
  assign auto_in_d_bits_source = d_resp.source;
  assign auto_in_d_bits_data   = d_resp.data;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Directed bench for tl_ram_slave: D fires are logged by a monitor and each
// scenario task compares the log against hand-computed responses.
module tb_tl_ram_slave;
  import tl_ram_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [1:0]  a_size = '0;
  logic [10:0] a_source = '0;
  logic [28:0] a_address = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_data = '0;
  logic        a_corrupt = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [10:0] d_source;
  logic [63:0] d_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_d = 0;
  tl_d_resp_t q[$];

  tl_ram_slave dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_data    (d_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (d_valid && d_ready) q.push_back('{opcode: d_opcode, size: d_size, source: d_source, data: d_data});
    if (first_d < 0 && d_valid) first_d = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] op, input logic [28:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic [10:0] src, input logic corrupt,
                      input logic [1:0] size);
    a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    a_source = src; a_corrupt = corrupt; a_size = size; a_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (a_ready) begin
        @(posedge clock); #1;
        a_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    checks++; failures++;
    $display("FAIL send_timeout src=%0d a_ready never high in 40 cycles", src);
  endtask

  task automatic wait_resp(input int n, input string name);
    int t = 0;
    while (q.size() < n && t < n + 40) begin
      @(posedge clock); #1;
      t++;
    end
    if (q.size() < n) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=%0d responses required=%0d", name, q.size(), n);
    end
    repeat (3) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
    checks++; if ({d_opcode, d_source, d_data} !== '0) begin failures++; $display("FAIL rst_d_bits got=%h exp=0", {d_opcode, d_source, d_data}); end
    reset = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_release_a_ready got=%b exp=1", a_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_put_get();
    q.delete();
    send(TL_A_PUTFULL, 29'h40, 8'hFF, 64'h1122334455667788, 11'd5, 1'b0, 2'd3);
    send(TL_A_GET, 29'h40, 8'h00, 64'h0, 11'd6, 1'b0, 2'd3);
    wait_resp(2, "put_get");
    checks++; if (q[0].opcode !== TL_D_ACCESSACK || q[0].source !== 11'd5 || q[0].data !== 64'h0)
      begin failures++; $display("FAIL pg_put_ack got=%0d/%0d/%h exp=0/5/0", q[0].opcode, q[0].source, q[0].data); end
    checks++; if (q[1].opcode !== TL_D_ACCESSACKDATA || q[1].source !== 11'd6 || q[1].size !== 2'd3)
      begin failures++; $display("FAIL pg_get_hdr got=%0d/%0d/%0d exp=1/6/3", q[1].opcode, q[1].source, q[1].size); end
    checks++; if (q[1].data !== 64'h1122334455667788)
      begin failures++; $display("FAIL pg_get_data got=%h exp=1122334455667788", q[1].data); end
  endtask

  task automatic test_partial();
    q.delete();
    send(TL_A_PUTFULL, 29'h0, 8'hFF, 64'h0, 11'd1, 1'b0, 2'd3);
    send(TL_A_PUTPARTIAL, 29'h0, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 11'd2, 1'b0, 2'd2);
    send(TL_A_GET, 29'h0, 8'h00, 64'h0, 11'd3, 1'b0, 2'd3);
    send(TL_A_PUTPARTIAL, 29'h0, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 11'd4, 1'b1, 2'd3);
    send(TL_A_GET, 29'h0, 8'h00, 64'h0, 11'd5, 1'b0, 2'd3);
    send(TL_A_PUTPARTIAL, 29'h0, 8'h81, 64'h11111111_11111111, 11'd6, 1'b0, 2'd3);
    send(TL_A_GET, 29'h0, 8'h00, 64'h0, 11'd7, 1'b0, 2'd3);
    wait_resp(7, "partial");
    checks++; if (q[1].opcode !== TL_D_ACCESSACK || q[1].size !== 2'd2)
      begin failures++; $display("FAIL pp_ack got=%0d/%0d exp=0/2", q[1].opcode, q[1].size); end
    checks++; if (q[2].data !== 64'h00000000_AAAAAAAA)
      begin failures++; $display("FAIL pp_get_data got=%h exp=00000000aaaaaaaa", q[2].data); end
    checks++; if (q[3].opcode !== TL_D_ACCESSACK || q[3].source !== 11'd4)
      begin failures++; $display("FAIL pp_corrupt_ack got=%0d/%0d exp=0/4", q[3].opcode, q[3].source); end
    checks++; if (q[4].data !== 64'h00000000_AAAAAAAA)
      begin failures++; $display("FAIL pp_corrupt_nowrite got=%h exp=00000000aaaaaaaa", q[4].data); end
    checks++; if (q[6].data !== 64'h11000000_AAAAAA11)
      begin failures++; $display("FAIL pp_mask81_data got=%h exp=11000000aaaaaa11", q[6].data); end
  endtask

  task automatic test_back_to_back();
    q.delete();
    send(TL_A_PUTFULL, 29'h80, 8'hFF, 64'h1234, 11'd8, 1'b0, 2'd3);
    wait_resp(1, "b2b_setup");
    q.delete();
    send(TL_A_GET, 29'h80, 8'h00, 64'h0, 11'd9, 1'b0, 2'd3);
    send(TL_A_PUTFULL, 29'h80, 8'hFF, 64'h5, 11'd10, 1'b0, 2'd3);
    send(TL_A_GET, 29'h80, 8'h00, 64'h0, 11'd11, 1'b0, 2'd3);
    wait_resp(3, "b2b");
    checks++; if (q[0].source !== 11'd9 || q[0].data !== 64'h1234)
      begin failures++; $display("FAIL b2b_get_old got=%0d/%h exp=9/1234", q[0].source, q[0].data); end
    checks++; if (q[1].source !== 11'd10 || q[1].opcode !== TL_D_ACCESSACK)
      begin failures++; $display("FAIL b2b_put_ack got=%0d/%0d exp=10/0", q[1].source, q[1].opcode); end
    checks++; if (q[2].source !== 11'd11 || q[2].data !== 64'h5)
      begin failures++; $display("FAIL b2b_get_new got=%0d/%h exp=11/5", q[2].source, q[2].data); end
  endtask

  task automatic test_unsupported_alias();
    q.delete();
    send(3'd2, 29'h40, 8'hFF, 64'hDEADBEEF_DEADBEEF, 11'd12, 1'b0, 2'd3);
    send(TL_A_GET, 29'h2047, 8'h00, 64'h0, 11'd13, 1'b0, 2'd3);
    wait_resp(2, "unsup");
    checks++; if (q[0].opcode !== TL_D_ACCESSACKDATA || q[0].data !== 64'h1122334455667788)
      begin failures++; $display("FAIL unsup_resp got=%0d/%h exp=1/1122334455667788", q[0].opcode, q[0].data); end
    checks++; if (q[1].source !== 11'd13 || q[1].data !== 64'h1122334455667788)
      begin failures++; $display("FAIL alias_get got=%0d/%h exp=13/1122334455667788", q[1].source, q[1].data); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int errs = 0;
    q.delete();
    d_ready = 1'b0;
    a_opcode = TL_A_GET; a_address = 29'h40; a_mask = 8'h00; a_size = 2'd3; a_corrupt = 1'b0;
    a_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      a_source = 11'(20 + acc);
      @(negedge clock);
      if (a_ready) acc++;
      @(posedge clock); #1;
    end
    checks++; if (acc !== 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", acc); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_a_ready_low got=%b exp=0", a_ready); end
    checks++; if (d_valid !== 1'b1 || d_source !== 11'd20)
      begin failures++; $display("FAIL bp_d_hold got=%b/%0d exp=1/20", d_valid, d_source); end
    d_ready = 1'b1;
    @(negedge clock);
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_before_pop got=%b exp=0", a_ready); end
    @(posedge clock); #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL bp_after_pop got=%b exp=1", a_ready); end
    for (int t = 0; t < 10 && acc < 5; t++) begin
      a_source = 11'(20 + acc);
      @(negedge clock);
      if (a_ready) acc++;
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    wait_resp(5, "bp");
    for (int i = 0; i < 5; i++) if (q[i].source !== 11'(20 + i)) errs++;
    checks++; if (q.size() !== 5 || errs !== 0)
      begin failures++; $display("FAIL bp_order got=%0d responses %0d misordered exp=5 0", q.size(), errs); end
  endtask

  task automatic test_throughput();
    int acc = 0;
    int lows = 0;
    int fire0 = -1;
    int errs = 0;
    q.delete();
    d_ready = 1'b1;
    first_d = -1;
    a_opcode = TL_A_GET; a_address = 29'h80; a_mask = 8'h00; a_size = 2'd3; a_corrupt = 1'b0;
    a_valid = 1'b1;
    for (int t = 0; t < 300 && acc < 100; t++) begin
      a_source = 11'(acc);
      @(negedge clock);
      if (!a_ready) lows++;
      else begin
        if (fire0 < 0) fire0 = cyc;
        acc++;
      end
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    wait_resp(100, "tput");
    for (int i = 0; i < 100; i++) if (q[i].source !== 11'(i) || q[i].data !== 64'h5) errs++;
    checks++; if (lows !== 0) begin failures++; $display("FAIL tput_a_ready_low got=%0d exp=0", lows); end
    checks++; if (q.size() !== 100 || errs !== 0)
      begin failures++; $display("FAIL tput_resps got=%0d responses %0d bad exp=100 0", q.size(), errs); end
    checks++; if (first_d - fire0 !== 2)
      begin failures++; $display("FAIL tput_latency got=%0d exp=2", first_d - fire0); end
  endtask

  task automatic test_reset_midflight();
    q.delete();
    d_ready = 1'b0;
    send(TL_A_GET, 29'h40, 8'h00, 64'h0, 11'd30, 1'b0, 2'd3);
    send(TL_A_GET, 29'h40, 8'h00, 64'h0, 11'd31, 1'b0, 2'd3);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (d_valid !== 1'b0 || a_ready !== 1'b0)
      begin failures++; $display("FAIL mid_rst_outputs got=%b/%b exp=0/0", d_valid, a_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1 || d_valid !== 1'b0)
      begin failures++; $display("FAIL mid_rst_release got=%b/%b exp=1/0", a_ready, d_valid); end
    d_ready = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    checks++; if (q.size() !== 0) begin failures++; $display("FAIL mid_rst_stale got=%0d exp=0", q.size()); end
  endtask

  task automatic test_intent();
    q.delete();
    send(TL_A_INTENT, 29'h40, 8'hFF, 64'hDEAD, 11'd40, 1'b0, 2'd1);
    send(TL_A_GET, 29'h40, 8'h00, 64'h0, 11'd41, 1'b0, 2'd3);
    wait_resp(2, "intent");
    checks++; if (q[0].opcode !== TL_D_HINTACK || q[0].data !== 64'h0 || q[0].source !== 11'd40 || q[0].size !== 2'd1)
      begin failures++; $display("FAIL intent_resp got=%0d/%h/%0d/%0d exp=2/0/40/1", q[0].opcode, q[0].data, q[0].source, q[0].size); end
    checks++; if (q[1].data !== 64'h1122334455667788)
      begin failures++; $display("FAIL intent_nowrite got=%h exp=1122334455667788", q[1].data); end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_back_to_back();
    test_unsupported_alias();
    test_backpressure();
    test_throughput();
    test_reset_midflight();
    test_intent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
